mult_arbiter: RTL and testbench

//   Shares one pipelined 16x16 unsigned multiplier (Mult, fixed 3-cycle latency, no stall input)

---
 rtl/mult_arb_pkg.sv | 22 ++
 rtl/mult_arb_fifo.sv | 75 +++++++
 rtl/mult_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mult_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared constants and tracking-pipe record for the multiplier arbiter.
package mult_arb_pkg;

    localparam int MULT_OP_W    = 16;
    localparam int MULT_RES_W   = 32;
    localparam int MULT_LAT_DEF = 3;

    // Tracking fields are sized for the widest legal configuration (TAG_W<=16, NUM_REQ<=8).
    localparam int TRK_TAG_W = 16;
    localparam int TRK_SRC_W = 3;

    typedef struct packed {
        logic                 valid;
        logic [TRK_TAG_W-1:0] tag;
        logic [TRK_SRC_W-1:0] src;
    } mult_trk_t;

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mult_arb_fifo.sv
// Result FIFO holding {product, tag, source}; head is read combinationally.
module mult_arb_fifo
    import mult_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int SRC_W = 2
)
(
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       push,
    input  logic [MULT_RES_W-1:0]      push_data,
    input  logic [TAG_W-1:0]           push_tag,
    input  logic [SRC_W-1:0]           push_src,
    input  logic                       pop,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [MULT_RES_W-1:0]      head_data,
    output logic [TAG_W-1:0]           head_tag,
    output logic [SRC_W-1:0]           head_src
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [MULT_RES_W-1:0] mem_data [DEPTH];
    logic [TAG_W-1:0]      mem_tag  [DEPTH];
    logic [SRC_W-1:0]      mem_src  [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  full;
    logic                  pop_eff;

    function automatic logic [PTR_W-1:0] adv(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign pop_eff   = pop && !empty;
    assign head_data = mem_data[rd_ptr];
    assign head_tag  = mem_tag[rd_ptr];
    assign head_src  = mem_src[rd_ptr];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_tag[i]  <= '0;
                mem_src[i]  <= '0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= push_data;
                mem_tag[wr_ptr]  <= push_tag;
                mem_src[wr_ptr]  <= push_src;
                wr_ptr           <= adv(wr_ptr);
            end
            if (pop_eff)
                rd_ptr <= adv(rd_ptr);
            if (push && !pop_eff)
                count <= count + CNT_W'(1);
            else if (!push && pop_eff)
                count <= count - CNT_W'(1);
        end
    end

    // Upstream credit accounting must make this unreachable.
    a_no_overflow: assert property (@(posedge Clk) disable iff (Rst) !(push && full && !pop));

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined multiplier with credit-protected result FIFO.
// Optional MULT_ARB_STATS_EN adds saturating issue/stall counters.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int TAG_W      = 4,
    parameter int MULT_LAT   = MULT_LAT_DEF,
    parameter int FIFO_DEPTH = 4
)
(
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic [NUM_REQ-1:0]             Req_Valid,
    output logic [NUM_REQ-1:0]             Req_Ready,
    input  logic [NUM_REQ*MULT_OP_W-1:0]   Req_OpA,
    input  logic [NUM_REQ*MULT_OP_W-1:0]   Req_OpB,
    input  logic [NUM_REQ*TAG_W-1:0]       Req_Tag,
    output logic [MULT_OP_W-1:0]           Mult_OpA,
    output logic [MULT_OP_W-1:0]           Mult_OpB,
    input  logic [MULT_RES_W-1:0]          Mult_Result,
    output logic                           Res_Valid,
    input  logic                           Res_Ready,
    output logic [MULT_RES_W-1:0]          Res_Data,
    output logic [TAG_W-1:0]               Res_Tag,
    output logic [$clog2(NUM_REQ)-1:0]     Res_Src,
    output logic                           Busy
`ifdef MULT_ARB_STATS_EN
    ,
    output logic [31:0]                    Stat_Issue,
    output logic [31:0]                    Stat_Stall
`endif
);

    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(MULT_LAT + 1);

    mult_trk_t          trk [MULT_LAT];
    mult_trk_t          trk_in;
    mult_trk_t          trk_last;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   gnt_idx;
    logic               gnt_found;
    logic               grant;
    logic               has_credit;
    logic [TAG_W-1:0]   gnt_tag;
    logic [INF_W-1:0]   inflight;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    int                 occ;
    int                 cand;
    logic               unused_trk;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MULT_LAT; i++)
            inflight = inflight + INF_W'(trk[i].valid);
    end

    // A pop this cycle is deliberately not counted: credit only frees after it has happened.
    always_comb begin
        occ        = int'(fifo_count) + int'(inflight);
        has_credit = (occ < FIFO_DEPTH);
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ)
                cand = cand - NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!gnt_found && cand == j && Req_Valid[j]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = SRC_W'(j);
                end
            end
        end
    end

    assign grant = gnt_found && has_credit && !Rst;

    always_comb begin
        Req_Ready = '0;
        Mult_OpA  = '0;
        Mult_OpB  = '0;
        gnt_tag   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant && gnt_idx == SRC_W'(i)) begin
                Req_Ready[i] = 1'b1;
                Mult_OpA     = Req_OpA[i*MULT_OP_W +: MULT_OP_W];
                Mult_OpB     = Req_OpB[i*MULT_OP_W +: MULT_OP_W];
                gnt_tag      = Req_Tag[i*TAG_W +: TAG_W];
            end
        end
    end

    always_comb begin
        trk_in       = '0;
        trk_in.valid = grant;
        trk_in.tag   = TRK_TAG_W'(gnt_tag);
        trk_in.src   = TRK_SRC_W'(gnt_idx);
    end

    // Tracking record walks alongside the multiplier so each product meets its tag.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rr_ptr <= '0;
            for (int i = 0; i < MULT_LAT; i++)
                trk[i] <= '0;
        end else begin
            trk[0] <= trk_in;
            for (int i = 1; i < MULT_LAT; i++)
                trk[i] <= trk[i-1];
            if (grant)
                rr_ptr <= SRC_W'(next_idx(int'(gnt_idx), NUM_REQ));
        end
    end

    assign trk_last   = trk[MULT_LAT-1];
    assign unused_trk = ^trk_last;

    mult_arb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .TAG_W (TAG_W),
        .SRC_W (SRC_W)
    ) u_fifo (
        .Clk       (Clk),
        .Rst       (Rst),
        .push      (trk_last.valid),
        .push_data (Mult_Result),
        .push_tag  (trk_last.tag[TAG_W-1:0]),
        .push_src  (trk_last.src[SRC_W-1:0]),
        .pop       (Res_Valid && Res_Ready),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head_data (Res_Data),
        .head_tag  (Res_Tag),
        .head_src  (Res_Src)
    );

    assign Res_Valid = !fifo_empty;
    assign Busy      = (inflight != '0) || !fifo_empty;

`ifdef MULT_ARB_STATS_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Stat_Issue <= '0;
            Stat_Stall <= '0;
        end else begin
            if (grant && Stat_Issue != '1)
                Stat_Issue <= Stat_Issue + 32'd1;
            if (|Req_Valid && !has_credit && Stat_Stall != '1)
                Stat_Stall <= Stat_Stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: directed scenarios followed by random traffic.
`timescale 1ns/1ps
module tb_mult_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int TAG_W      = 4;
    localparam int MULT_LAT   = 3;
    localparam int FIFO_DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [3:0]  Req_Valid;
    logic [3:0]  Req_Ready;
    logic [63:0] Req_OpA;
    logic [63:0] Req_OpB;
    logic [15:0] Req_Tag;
    logic [15:0] Mult_OpA;
    logic [15:0] Mult_OpB;
    logic [31:0] Mult_Result;
    logic        Res_Valid;
    logic        Res_Ready;
    logic [31:0] Res_Data;
    logic [3:0]  Res_Tag;
    logic [1:0]  Res_Src;
    logic        Busy;
`ifdef MULT_ARB_STATS_EN
    logic [31:0] Stat_Issue;
    logic [31:0] Stat_Stall;
`endif

    always #5 Clk = ~Clk;

    mult_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .TAG_W      (TAG_W),
        .MULT_LAT   (MULT_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Req_Valid   (Req_Valid),
        .Req_Ready   (Req_Ready),
        .Req_OpA     (Req_OpA),
        .Req_OpB     (Req_OpB),
        .Req_Tag     (Req_Tag),
        .Mult_OpA    (Mult_OpA),
        .Mult_OpB    (Mult_OpB),
        .Mult_Result (Mult_Result),
        .Res_Valid   (Res_Valid),
        .Res_Ready   (Res_Ready),
        .Res_Data    (Res_Data),
        .Res_Tag     (Res_Tag),
        .Res_Src     (Res_Src),
        .Busy        (Busy)
`ifdef MULT_ARB_STATS_EN
        ,
        .Stat_Issue  (Stat_Issue),
        .Stat_Stall  (Stat_Stall)
`endif
    );

    // Behavioural 3-stage multiplier sharing the arbiter reset.
    logic [31:0] mp [3];
    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            mp[0] <= '0; mp[1] <= '0; mp[2] <= '0;
        end else begin
            mp[0] <= {16'h0, Mult_OpA} * {16'h0, Mult_OpB};
            mp[1] <= mp[0];
            mp[2] <= mp[1];
        end
    end
    assign Mult_Result = mp[2];

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        int          src;
        int          rdy;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   issued = 0;
    int   popped = 0;
    logic [3:0] hs;
    logic       rv;
    logic [31:0] rd;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    endtask

    // Request side: expected grant from the round-robin/credit rule, push expected result.
    initial begin : arb_model
        int mptr, g, outst, j;
        logic [15:0] ea;
        mptr = 0;
        forever begin
            @(negedge Clk);
            if (Rst) begin
                check("rst_req_ready", {28'h0, Req_Ready}, 32'h0);
                exp_q.delete();
                mptr   = 0;
                issued = 0;
                continue;
            end
            outst = issued - popped;
            check("busy", {31'h0, Busy}, {31'h0, outst != 0});
            g = -1;
            if (outst < FIFO_DEPTH) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    j = (mptr + k) % NUM_REQ;
                    if (g < 0 && Req_Valid[j]) g = j;
                end
            end
            check("req_ready", {28'h0, Req_Ready}, (g >= 0) ? (32'h1 << g) : 32'h0);
            ea = (g >= 0) ? Req_OpA[16*g +: 16] : 16'h0;
            check("mult_opa", {16'h0, Mult_OpA}, {16'h0, ea});
            if (g >= 0) begin
                exp_q.push_back('{data: {16'h0, Req_OpA[16*g +: 16]} * {16'h0, Req_OpB[16*g +: 16]},
                                  tag:  Req_Tag[4*g +: 4],
                                  src:  g,
                                  rdy:  cyc + MULT_LAT + 1});
                mptr = (g + 1) % NUM_REQ;
                issued++;
            end
        end
    end

    // Result side: pop and compare whenever the DUT presents a result.
    initial begin : res_monitor
        exp_t it;
        logic exp_v;
        forever begin
            @(negedge Clk);
            if (Rst) begin
                check("rst_res_valid", {31'h0, Res_Valid}, 32'h0);
                check("rst_res_data", Res_Data, 32'h0);
                check("rst_res_tag_src", {26'h0, Res_Tag, Res_Src}, 32'h0);
                popped <= 0;
                continue;
            end
            exp_v = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
            check("res_valid", {31'h0, Res_Valid}, {31'h0, exp_v});
            if (Res_Valid && Res_Ready && exp_v) begin
                it = exp_q.pop_front();
                check("res_data", Res_Data, it.data);
                check("res_tag", {28'h0, Res_Tag}, {28'h0, it.tag});
                check("res_src", {30'h0, Res_Src}, it.src);
                popped <= popped + 1;
            end
        end
    end

    task automatic step();
        @(negedge Clk);
        hs = Req_Valid & Req_Ready;
        rv = Res_Valid;
        rd = Res_Data;
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
        Req_OpA[16*i +: 16] = a;
        Req_OpB[16*i +: 16] = b;
        Req_Tag[4*i +: 4]   = t;
        Req_Valid[i]        = 1'b1;
    endtask

    task automatic new_op(input int i);
        logic [15:0] a, b;
        int sel;
        sel = $urandom_range(0, 7);
        a = (sel == 0) ? 16'hFFFF : (sel == 1) ? 16'h0 : 16'($urandom);
        b = (sel == 0) ? 16'hFFFF : 16'($urandom);
        set_req(i, a, b, 4'($urandom));
    endtask

    task automatic do_reset();
        Req_Valid = '0;
        Rst = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    task automatic refresh_all();
        for (int i = 0; i < NUM_REQ; i++)
            if (hs[i]) new_op(i);
    endtask

    initial begin : main
        int n, gseq[$];
        logic [31:0] got[$];
        Rst = 1'b1; Req_Valid = '0; Res_Ready = 1'b0;
        Req_OpA = '0; Req_OpB = '0; Req_Tag = '0;
        #1;
        do_reset();

        // Single requester 3*5.
        Res_Ready = 1'b1;
        set_req(0, 16'd3, 16'd5, 4'd2);
        n = 0;
        do begin step(); n++; end while (!hs[0] && n < 6);
        check("t1_handshake", {31'h0, hs[0]}, 32'h1);
        Req_Valid[0] = 1'b0;
        repeat (8) step();

        // All requesters held valid: round-robin order.
        do_reset();
        Res_Ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'(i + 1), 16'(i + 7), 4'(i + 8));
        for (int c = 0; c < 24; c++) begin
            step();
            for (int i = 0; i < NUM_REQ; i++) if (hs[i]) gseq.push_back(i);
            refresh_all();
        end
        for (int j = 0; j < 8 && j < gseq.size(); j++) check("t2_rr_order", gseq[j], j % NUM_REQ);
        check("t2_grant_count_min", {31'h0, gseq.size() >= 8}, 32'h1);

        // Consumer stalled: credit caps issue at FIFO_DEPTH.
        do_reset();
        Res_Ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) new_op(i);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            n += $countones(hs);
            refresh_all();
        end
        check("t3_stall_issues", n, FIFO_DEPTH);
`ifdef MULT_ARB_STATS_EN
        check("t6_stat_issue", Stat_Issue, 32'd4);
        check("t6_stat_stall", Stat_Stall, 32'd6);
`endif
        Res_Ready = 1'b1;
        for (int c = 0; c < 20; c++) begin step(); refresh_all(); end

        // Operand extremes.
        do_reset();
        Res_Ready = 1'b1;
        set_req(1, 16'hFFFF, 16'hFFFF, 4'd5);
        set_req(2, 16'h0000, 16'h1234, 4'd6);
        for (int c = 0; c < 14; c++) begin
            step();
            for (int i = 0; i < NUM_REQ; i++) if (hs[i]) Req_Valid[i] = 1'b0;
            if (rv) got.push_back(rd);
        end
        check("t4_result_count", got.size(), 2);
        if (got.size() >= 2) begin
            check("t4_ffff_sq", got[0], 32'hFFFE0001);
            check("t4_zero", got[1], 32'h0);
        end

        // Reset with work in flight and buffered.
        do_reset();
        Res_Ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) new_op(i);
        for (int c = 0; c < 5; c++) begin step(); refresh_all(); end
        do_reset();
        check("t5_busy_after_rst", {31'h0, Busy}, 32'h0);
        Res_Ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) new_op(i);
        step();
        check("t5_first_grant", {28'h0, hs}, 32'h1);
        refresh_all();
        for (int c = 0; c < 12; c++) begin step(); refresh_all(); end

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            step();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hs[i] || !Req_Valid[i]) begin
                    if ($urandom_range(0, 2) != 0) new_op(i);
                    else Req_Valid[i] = 1'b0;
                end
            end
            Res_Ready = ($urandom_range(0, 3) != 0);
        end

        Req_Valid = '0;
        Res_Ready = 1'b1;
        repeat (30) step();
        check("drain_empty", exp_q.size(), 0);
        check("drain_busy", {31'h0, Busy}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
